// File: rtl/dut_port_arbiter_if.sv
// Requester-side and DUT-side signals of the port arbiter, bundled as one interface.
// The master modport is the environment (requesters plus DUT); slave is the arbiter.
interface dut_port_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 3
);
    logic [NUM_REQ-1:0]        req_wr_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_wr_addr;
    logic [NUM_REQ-1:0]        req_wr_data;
    logic [NUM_REQ-1:0]        req_wr_ready;
    logic [NUM_REQ-1:0]        req_rd_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_rd_addr;
    logic [NUM_REQ-1:0]        req_rd_ready;
    logic [NUM_REQ-1:0]        rsp_rd_valid;
    logic                      rsp_rd_data;
    logic [ADDR_W-1:0]         write_address;
    logic                      write_data;
    logic                      write_en;
    logic                      write_rdy;
    logic [ADDR_W-1:0]         read_address;
    logic                      read_en;
    logic                      read_data;
    logic                      read_rdy;
    logic                      wr_timeout;
    logic                      rd_timeout;

    modport master (
        output req_wr_valid, req_wr_addr, req_wr_data, req_rd_valid, req_rd_addr,
               write_rdy, read_data, read_rdy,
        input  req_wr_ready, req_rd_ready, rsp_rd_valid, rsp_rd_data,
               write_address, write_data, write_en, read_address, read_en,
               wr_timeout, rd_timeout
    );

    modport slave (
        input  req_wr_valid, req_wr_addr, req_wr_data, req_rd_valid, req_rd_addr,
               write_rdy, read_data, read_rdy,
        output req_wr_ready, req_rd_ready, rsp_rd_valid, rsp_rd_data,
               write_address, write_data, write_en, read_address, read_en,
               wr_timeout, rd_timeout
    );
endinterface

// File: rtl/dut_port_arbiter.sv
// Round-robin sharing of the DUT's single write and read ports between NUM_REQ requesters,
// with grant lock, registered read response, RAW hazard stall and per-port stall watchdogs.
module dut_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 3,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    dut_port_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t             wr_state, wr_state_nxt, rd_state, rd_state_nxt;
    logic [IDX_W-1:0]   wr_ptr, rd_ptr, wr_gnt, rd_gnt, wr_gnt_q, rd_gnt_q;
    logic               wr_active, wr_acc, rd_pending, rd_hazard, rd_acc;
    logic [CNT_W-1:0]   wr_cnt, wr_cnt_nxt, rd_cnt, rd_cnt_nxt;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic               rsp_data_q, wr_flag_q, rd_flag_q;

    // First valid requester at or after ptr, wrapping around.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] pick;
        int idx;
        pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (valid[idx]) pick = IDX_W'(idx);
        end
        return pick;
    endfunction

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] gnt);
        return (int'(gnt) == NUM_REQ - 1) ? '0 : gnt + 1'b1;
    endfunction

    // NOTE: every output of a combinational block is assigned a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        wr_state_nxt = wr_state;
        wr_gnt       = (wr_state == HOLD) ? wr_gnt_q : rr_pick(bus.req_wr_valid, wr_ptr);
        wr_active    = !reset && ((wr_state == HOLD) || (|bus.req_wr_valid));
        bus.write_en      = wr_active;
        bus.write_address = wr_active ? bus.req_wr_addr[int'(wr_gnt)*ADDR_W +: ADDR_W] : '0;
        bus.write_data    = wr_active ? bus.req_wr_data[wr_gnt] : 1'b0;
        wr_acc            = wr_active && bus.write_rdy;
        bus.req_wr_ready  = wr_acc ? (NUM_REQ'(1) << wr_gnt) : '0;
        wr_cnt_nxt = wr_acc ? '0 :
                     (wr_active && wr_cnt != CNT_MAX) ? wr_cnt + 1'b1 : wr_cnt;
        case (wr_state)
            IDLE:    if (wr_active && !wr_acc) wr_state_nxt = HOLD;
            HOLD:    if (wr_acc) wr_state_nxt = IDLE;
            default: wr_state_nxt = IDLE;
        endcase
    end

    // A pending read whose address matches the in-flight write waits a cycle, so the
    // stall is counted by the watchdog and the read sees post-write data.
    always_comb begin
        rd_state_nxt = rd_state;
        rd_gnt       = (rd_state == HOLD) ? rd_gnt_q : rr_pick(bus.req_rd_valid, rd_ptr);
        rd_pending   = !reset && ((rd_state == HOLD) || (|bus.req_rd_valid));
        bus.read_address = rd_pending ? bus.req_rd_addr[int'(rd_gnt)*ADDR_W +: ADDR_W] : '0;
        rd_hazard        = bus.write_en && (bus.write_address == bus.read_address);
        bus.read_en      = rd_pending && !rd_hazard;
        rd_acc           = bus.read_en && bus.read_rdy;
        bus.req_rd_ready = rd_acc ? (NUM_REQ'(1) << rd_gnt) : '0;
        rd_cnt_nxt = rd_acc ? '0 :
                     (rd_pending && rd_cnt != CNT_MAX) ? rd_cnt + 1'b1 : rd_cnt;
        case (rd_state)
            IDLE:    if (rd_pending && !rd_acc) rd_state_nxt = HOLD;
            HOLD:    if (rd_acc) rd_state_nxt = IDLE;
            default: rd_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge value of its inputs regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state <= IDLE;
            rd_state <= IDLE;
        end else begin
            wr_state <= wr_state_nxt;
            rd_state <= rd_state_nxt;
        end
    end

    // NOTE: reset clears every register here, including the pending response, so a
    // response accepted just before reset is dropped rather than delivered.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            wr_gnt_q    <= '0;
            rd_gnt_q    <= '0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            wr_flag_q   <= 1'b0;
            rd_flag_q   <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= next_ptr(wr_gnt);
            if (rd_acc) rd_ptr <= next_ptr(rd_gnt);
            if (wr_state == IDLE) wr_gnt_q <= wr_gnt;
            if (rd_state == IDLE) rd_gnt_q <= rd_gnt;
            wr_cnt <= wr_cnt_nxt;
            rd_cnt <= rd_cnt_nxt;
            if (wr_cnt_nxt == CNT_MAX) wr_flag_q <= 1'b1;
            if (rd_cnt_nxt == CNT_MAX) rd_flag_q <= 1'b1;
            rsp_valid_q <= rd_acc ? (NUM_REQ'(1) << rd_gnt) : '0;
            if (rd_acc) rsp_data_q <= bus.read_data;
        end
    end

    assign bus.rsp_rd_valid = rsp_valid_q;
    assign bus.rsp_rd_data  = rsp_data_q;
    assign bus.wr_timeout   = wr_flag_q;
    assign bus.rd_timeout   = rd_flag_q;
endmodule
